fetch_unit: RTL and testbench

- Front-end fetch stage for the single-cycle RV32I core. Sits directly upstream of instmemory.
- Owns the program counter and drives the byte address into instmemory. Samples the returned 32-bit word in the same cycle and registers it, with its PC, toward decode using a valid/ready handshake.
- Handles branch/jump redirects, back-pressure, end-of-program halt and misaligned/out-of-range fetch faults.

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: the instruction-memory side, the execute redirect,
// and the valid/ready slot toward decode.
interface fetch_unit_if;
    logic [31:0] addr;
    logic [31:0] instr_in;
    logic        last_flag_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_in;

    modport master (
        output addr, instr_out, pc_out, valid_out,
        input  instr_in, last_flag_in, redirect_valid, redirect_target, ready_in
    );

    modport slave (
        input  addr, instr_out, pc_out, valid_out,
        output instr_in, last_flag_in, redirect_valid, redirect_target, ready_in
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, registers one word toward decode per cycle,
// and handles redirects, back-pressure, end-of-program halt and fetch faults.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_BYTES  = 128,
    parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus,
    output logic         halted,
    output logic         fault,
    output logic [31:0]  fault_addr,
    output logic [31:0]  fetch_count
);
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_out_reg, pc_out_next;
    logic        valid_reg, valid_next;
    logic        halted_reg, halted_next;
    logic        fault_reg, fault_next;
    logic [31:0] fault_addr_reg, fault_addr_next;
    logic [31:0] count_reg, count_next;

    logic free;
    logic accept;
    logic bad_target;

    assign accept     = valid_reg && bus.ready_in;
    assign free       = !valid_reg || bus.ready_in;
    assign bad_target = (bus.redirect_target[1:0] != 2'b00) || (bus.redirect_target > LAST_PC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_PC;
            instr_reg      <= '0;
            pc_out_reg     <= '0;
            valid_reg      <= 1'b0;
            halted_reg     <= 1'b0;
            fault_reg      <= 1'b0;
            fault_addr_reg <= '0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            instr_reg      <= instr_next;
            pc_out_reg     <= pc_out_next;
            valid_reg      <= valid_next;
            halted_reg     <= halted_next;
            fault_reg      <= fault_next;
            fault_addr_reg <= fault_addr_next;
            count_reg      <= count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        instr_next      = instr_reg;
        pc_out_next     = pc_out_reg;
        valid_next      = valid_reg;
        halted_next     = halted_reg;
        fault_next      = fault_reg;
        fault_addr_next = fault_addr_reg;
        count_next      = count_reg + {31'd0, accept};

        case (state_reg)
            RUN: begin
                if (bus.redirect_valid) begin
                    // Redirect flushes the slot even when decode is stalling it.
                    valid_next = 1'b0;
                    if (bad_target) begin
                        fault_next      = 1'b1;
                        fault_addr_next = bus.redirect_target;
                        state_next      = FAULT;
                    end else begin
                        pc_next = bus.redirect_target;
                    end
                end else if (pc_reg > LAST_PC) begin
                    fault_next      = 1'b1;
                    fault_addr_next = pc_reg;
                    valid_next      = valid_reg && !bus.ready_in;
                    state_next      = FAULT;
                end else if (bus.instr_in == END_MARKER || bus.last_flag_in) begin
                    halted_next = 1'b1;
                    valid_next  = valid_reg && !bus.ready_in;
                    state_next  = HALT;
                end else if (free) begin
                    instr_next  = bus.instr_in;
                    pc_out_next = pc_reg;
                    valid_next  = 1'b1;
                    pc_next     = pc_reg + 32'd4;
                end
            end
            HALT, FAULT: begin
                // Terminal states only drain the held word.
                valid_next = valid_reg && !bus.ready_in;
            end
            default: state_next = RUN;
        endcase
    end

    assign bus.addr      = pc_reg;
    assign bus.instr_out = instr_reg;
    assign bus.pc_out    = pc_out_reg;
    assign bus.valid_out = valid_reg;
    assign halted        = halted_reg;
    assign fault         = fault_reg;
    assign fault_addr    = fault_addr_reg;
    assign fetch_count   = count_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for the stream, stall, redirect,
// fault and reset cases, plus a hand-run out-of-range sequence.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        halted, fault;
    logic [31:0] fault_addr, fetch_count;
    logic [31:0] mem [0:31];

    int checks = 0;
    int errors = 0;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .MEM_BYTES  (128),
        .END_MARKER (32'hFFFF_FFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .halted      (halted),
        .fault       (fault),
        .fault_addr  (fault_addr),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    assign bus.instr_in     = (bus.addr < 32'd128) ? mem[bus.addr[6:2]] : 32'h0;
    assign bus.last_flag_in = 1'b0;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        rv;
        logic [31:0] rt;
        logic        e_valid;
        logic [31:0] e_pc_out;
        logic [31:0] e_addr;
        logic        e_halted;
        logic        e_fault;
        logic [31:0] e_fault_addr;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs [0:30];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] rt,
                                input logic v, input logic [31:0] pco, input logic [31:0] a,
                                input logic h, input logic f, input logic [31:0] fa, input logic [31:0] c);
        vec_t x;
        x.rst = r; x.ready = rdy; x.rv = rv; x.rt = rt;
        x.e_valid = v; x.e_pc_out = pco; x.e_addr = a;
        x.e_halted = h; x.e_fault = f; x.e_fault_addr = fa; x.e_count = c;
        return x;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = word_at(32'(i * 4));
        mem[4] = 32'hFFFF_FFFF;

        //            rst rdy rv  rt       | v  pc_out  addr   h  f  f_addr  count
        // straight-line to the end marker, then a redirect that HALT ignores
        vecs[0]  = mk(1, 1, 0, 0,            0, 0,      0,     0, 0, 0,     0);
        vecs[1]  = mk(0, 1, 0, 0,            1, 0,      4,     0, 0, 0,     0);
        vecs[2]  = mk(0, 1, 0, 0,            1, 4,      8,     0, 0, 0,     1);
        vecs[3]  = mk(0, 1, 0, 0,            1, 8,      12,    0, 0, 0,     2);
        vecs[4]  = mk(0, 1, 0, 0,            1, 12,     16,    0, 0, 0,     3);
        vecs[5]  = mk(0, 1, 0, 0,            0, 12,     16,    1, 0, 0,     4);
        vecs[6]  = mk(0, 1, 1, 32'h20,       0, 12,     16,    1, 0, 0,     4);
        // back-pressure for three cycles
        vecs[7]  = mk(1, 1, 0, 0,            0, 0,      0,     0, 0, 0,     0);
        vecs[8]  = mk(0, 1, 0, 0,            1, 0,      4,     0, 0, 0,     0);
        vecs[9]  = mk(0, 1, 0, 0,            1, 4,      8,     0, 0, 0,     1);
        vecs[10] = mk(0, 0, 0, 0,            1, 4,      8,     0, 0, 0,     1);
        vecs[11] = mk(0, 0, 0, 0,            1, 4,      8,     0, 0, 0,     1);
        vecs[12] = mk(0, 0, 0, 0,            1, 4,      8,     0, 0, 0,     1);
        vecs[13] = mk(0, 1, 0, 0,            1, 8,      12,    0, 0, 0,     2);
        vecs[14] = mk(0, 1, 0, 0,            1, 12,     16,    0, 0, 0,     3);
        // redirect over a stalled slot
        vecs[15] = mk(1, 1, 0, 0,            0, 0,      0,     0, 0, 0,     0);
        vecs[16] = mk(0, 1, 0, 0,            1, 0,      4,     0, 0, 0,     0);
        vecs[17] = mk(0, 0, 1, 32'h20,       0, 0,      32'h20, 0, 0, 0,    0);
        vecs[18] = mk(0, 1, 0, 0,            1, 32'h20, 32'h24, 0, 0, 0,    0);
        vecs[19] = mk(0, 1, 0, 0,            1, 32'h24, 32'h28, 0, 0, 0,    1);
        // misaligned redirect, then FAULT ignores everything
        vecs[20] = mk(0, 1, 1, 32'h22,       0, 32'h24, 32'h28, 0, 1, 32'h22, 2);
        vecs[21] = mk(0, 1, 1, 32'h20,       0, 32'h24, 32'h28, 0, 1, 32'h22, 2);
        vecs[22] = mk(0, 1, 0, 0,            0, 32'h24, 32'h28, 0, 1, 32'h22, 2);
        // reset mid-stream with a redirect pending
        vecs[23] = mk(1, 1, 0, 0,            0, 0,      0,     0, 0, 0,     0);
        vecs[24] = mk(0, 1, 0, 0,            1, 0,      4,     0, 0, 0,     0);
        vecs[25] = mk(0, 1, 0, 0,            1, 4,      8,     0, 0, 0,     1);
        vecs[26] = mk(0, 1, 0, 0,            1, 8,      12,    0, 0, 0,     2);
        vecs[27] = mk(0, 1, 0, 0,            1, 12,     16,    0, 0, 0,     3);
        vecs[28] = mk(1, 1, 1, 32'h40,       0, 0,      0,     0, 0, 0,     0);
        vecs[29] = mk(0, 1, 0, 0,            1, 0,      4,     0, 0, 0,     0);
        // aligned but out-of-range redirect target
        vecs[30] = mk(0, 1, 1, 32'h80,       0, 0,      4,     0, 1, 32'h80, 1);

        rst = 1'b1;
        bus.ready_in = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;

        for (int i = 0; i <= 30; i++) begin
            rst                 = vecs[i].rst;
            bus.ready_in        = vecs[i].ready;
            bus.redirect_valid  = vecs[i].rv;
            bus.redirect_target = vecs[i].rt;
            @(posedge clk);
            #1;
            $display("row %0d: valid=%0b pc_out=%h instr=%h addr=%h halted=%0b fault=%0b fault_addr=%h count=%0d",
                     i, bus.valid_out, bus.pc_out, bus.instr_out, bus.addr, halted, fault, fault_addr, fetch_count);
            chk("valid_out",   i, {31'd0, bus.valid_out}, {31'd0, vecs[i].e_valid});
            chk("pc_out",      i, bus.pc_out,             vecs[i].e_pc_out);
            chk("addr",        i, bus.addr,               vecs[i].e_addr);
            chk("halted",      i, {31'd0, halted},        {31'd0, vecs[i].e_halted});
            chk("fault",       i, {31'd0, fault},         {31'd0, vecs[i].e_fault});
            chk("fault_addr",  i, fault_addr,             vecs[i].e_fault_addr);
            chk("fetch_count", i, fetch_count,            vecs[i].e_count);
            if (vecs[i].e_valid)
                chk("instr_out", i, bus.instr_out, word_at(vecs[i].e_pc_out));
        end

        // Out-of-range sequential fetch: no end marker anywhere in memory.
        mem[4] = word_at(32'h10);
        bus.redirect_valid = 1'b0;
        bus.ready_in = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            int n;
            n = 0;
            while (!fault && n < 60) begin
                @(posedge clk);
                #1;
                n++;
            end
            $display("oor: cycles=%0d fault=%0b fault_addr=%h pc_out=%h instr=%h valid=%0b count=%0d",
                     n, fault, fault_addr, bus.pc_out, bus.instr_out, bus.valid_out, fetch_count);
            chk("oor_reached",    100, {31'd0, fault}, 32'd1);
            chk("oor_cycles",     100, 32'(n),          32'd33);
            chk("oor_fault_addr", 100, fault_addr,      32'h80);
            chk("oor_pc_out",     100, bus.pc_out,      32'h7C);
            chk("oor_instr",      100, bus.instr_out,   word_at(32'h7C));
            chk("oor_valid",      100, {31'd0, bus.valid_out}, 32'd0);
            chk("oor_count",      100, fetch_count,     32'd32);
            chk("oor_addr",       100, bus.addr,        32'h80);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
